// File: rtl/fp_mul_pkg.sv
// Shared types and constants for the FP32 multiply sequencer.
//  state_e  : sequencer FSM states
//  class_e  : operand classification (denormals are reported as zero)
//  QNAN     : canonical quiet NaN returned for invalid operations and timeouts
//  EXP_MAX  : all-ones biased exponent (Inf/NaN)
//  FLAG_*   : bit positions inside the 4-bit result flag vector
package fp_mul_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StWait,
    StNorm,
    StOut
  } state_e;

  typedef enum logic [1:0] {
    ClsZero,
    ClsNormal,
    ClsInf,
    ClsNan
  } class_e;

  localparam logic [31:0] QNAN    = 32'h7FC0_0000;
  localparam logic [7:0]  EXP_MAX = 8'hFF;

  localparam int unsigned FLAG_INVALID   = 0;
  localparam int unsigned FLAG_OVERFLOW  = 1;
  localparam int unsigned FLAG_UNDERFLOW = 2;
  localparam int unsigned FLAG_TIMEOUT   = 3;

endpackage

// File: rtl/fp_operand_class.sv
// Combinational IEEE-754 single-precision operand classifier.
//  op   in   32  operand
//  cls  out  2   ClsZero / ClsNormal / ClsInf / ClsNan
//  sign out  1   sign bit
//  exp  out  8   biased exponent field
//  mant out  23  fraction field
// Denormals (exp==0, mant!=0) are classified as zero so they get flushed.
module fp_operand_class
  import fp_mul_pkg::*;
(
  input  logic [31:0] op,
  output class_e      cls,
  output logic        sign,
  output logic [7:0]  exp,
  output logic [22:0] mant
);

  assign sign = op[31];
  assign exp  = op[30:23];
  assign mant = op[22:0];

  always_comb begin
    cls = ClsNormal;
    if (exp == EXP_MAX) begin
      cls = (mant != '0) ? ClsNan : ClsInf;
    end else if (exp == 8'h00) begin
      cls = ClsZero;
    end
  end

endmodule

// File: rtl/fp_mul_sequencer.sv
// Controller for the FP32 multiply path. Captures an operand pair, resolves Zero/Inf/NaN
// combinations locally and sends normal pairs to an external 24x24 mantissa multiplier, then
// normalises (truncating) and packs the product.
//  clk, rst              clock (rising edge), asynchronous active-high reset
//  in_valid/in_ready     operand handshake; in_ready is high only in StIdle
//  in_a, in_b            IEEE-754 single operands
//  mul_start             one-cycle request to the multiplier
//  mul_a, mul_b          {1,mantissa}, stable from mul_start until WAIT is left, else 0
//  mul_done, mul_p       multiplier product valid / 48-bit product (sampled only in WAIT)
//  res_valid/res_ready   result handshake; res and res_flags held until accepted
//  res_flags             {timeout, underflow, overflow, invalid}
// Optional feature macro FPM_STICKY_FLAGS_EN adds flags_clr (in) and sticky_flags (out), an
// accumulation of res_flags over accepted results.
module fp_mul_sequencer
  import fp_mul_pkg::*;
#(
  parameter int unsigned BIAS    = 127,
  parameter int unsigned TIMEOUT = 32
) (
  input  logic        clk,
  input  logic        rst,
`ifdef FPM_STICKY_FLAGS_EN
  input  logic        flags_clr,
  output logic [3:0]  sticky_flags,
`endif
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  output logic        mul_start,
  output logic [23:0] mul_a,
  output logic [23:0] mul_b,
  input  logic        mul_done,
  input  logic [47:0] mul_p,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res,
  output logic [3:0]  res_flags
);

  localparam int unsigned WdogW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [WdogW-1:0] WdogLast = WdogW'(TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [31:0]      a_q, a_d, b_q, b_d;
  // Only p[47:23] matters after truncation: leading bit plus 24 candidate mantissa bits.
  logic [24:0]      p_q, p_d;
  logic [WdogW-1:0] wdog_q, wdog_d;
  logic [31:0]      res_q, res_d;
  logic [3:0]       flags_q, flags_d;

  logic       unused_mul_p;
  assign unused_mul_p = ^mul_p[22:0];

  class_e      cls_a, cls_b;
  logic        sign_a, sign_b, sign_r;
  logic [7:0]  exp_a, exp_b;
  logic [22:0] mant_a, mant_b;

  fp_operand_class u_class_a (
    .op   (a_q),
    .cls  (cls_a),
    .sign (sign_a),
    .exp  (exp_a),
    .mant (mant_a)
  );

  fp_operand_class u_class_b (
    .op   (b_q),
    .cls  (cls_b),
    .sign (sign_b),
    .exp  (exp_b),
    .mant (mant_b)
  );

  assign sign_r = sign_a ^ sign_b;

  // Special-case resolution, in priority order.
  logic        special;
  logic [31:0] special_res;
  logic [3:0]  special_flags;

  always_comb begin
    special       = 1'b1;
    special_res   = QNAN;
    special_flags = '0;
    if (cls_a == ClsNan || cls_b == ClsNan) begin
      special_flags[FLAG_INVALID] = 1'b1;
    end else if ((cls_a == ClsInf && cls_b == ClsZero) || (cls_a == ClsZero && cls_b == ClsInf)) begin
      special_flags[FLAG_INVALID] = 1'b1;
    end else if (cls_a == ClsInf || cls_b == ClsInf) begin
      special_res = {sign_r, EXP_MAX, 23'd0};
    end else if (cls_a == ClsZero || cls_b == ClsZero) begin
      special_res = {sign_r, 8'h00, 23'd0};
    end else begin
      special = 1'b0;
    end
  end

  // Normalisation of the latched product.
  logic signed [9:0] e_raw, e_adj;
  logic [22:0]       m_norm;
  logic [31:0]       norm_res;
  logic [3:0]        norm_flags;

  always_comb begin
    e_raw      = $signed({2'b00, exp_a}) + $signed({2'b00, exp_b}) - $signed(10'(BIAS));
    e_adj      = e_raw + $signed({9'd0, p_q[24]});
    m_norm     = p_q[24] ? p_q[23:1] : p_q[22:0];
    norm_flags = '0;
    if (e_adj >= 10'sd255) begin
      norm_res                  = {sign_r, EXP_MAX, 23'd0};
      norm_flags[FLAG_OVERFLOW] = 1'b1;
    end else if (e_adj <= 10'sd0) begin
      norm_res                   = {sign_r, 8'h00, 23'd0};
      norm_flags[FLAG_UNDERFLOW] = 1'b1;
    end else begin
      norm_res = {sign_r, e_adj[7:0], m_norm};
    end
  end

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    p_d       = p_q;
    wdog_d    = wdog_q;
    res_d     = res_q;
    flags_d   = flags_q;
    mul_start = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          a_d     = in_a;
          b_d     = in_b;
          state_d = StIssue;
        end
      end
      StIssue: begin
        wdog_d = '0;
        if (special) begin
          res_d   = special_res;
          flags_d = special_flags;
          state_d = StOut;
        end else begin
          mul_start = 1'b1;
          state_d   = StWait;
        end
      end
      StWait: begin
        // A product arriving on the last watchdog cycle is still taken.
        if (mul_done) begin
          p_d     = mul_p[47:23];
          state_d = StNorm;
        end else if (wdog_q == WdogLast) begin
          res_d                 = QNAN;
          flags_d               = '0;
          flags_d[FLAG_TIMEOUT] = 1'b1;
          state_d               = StOut;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
      end
      StNorm: begin
        res_d   = norm_res;
        flags_d = norm_flags;
        state_d = StOut;
      end
      StOut: begin
        if (res_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      p_q     <= '0;
      wdog_q  <= '0;
      res_q   <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      p_q     <= p_d;
      wdog_q  <= wdog_d;
      res_q   <= res_d;
      flags_q <= flags_d;
    end
  end

  logic mul_hold;
  assign mul_hold  = (state_q == StIssue && !special) || state_q == StWait;
  assign mul_a     = mul_hold ? {1'b1, mant_a} : '0;
  assign mul_b     = mul_hold ? {1'b1, mant_b} : '0;
  assign in_ready  = (state_q == StIdle);
  assign res_valid = (state_q == StOut);
  assign res       = res_q;
  assign res_flags = flags_q;

`ifdef FPM_STICKY_FLAGS_EN
  logic [3:0] sticky_q, sticky_d;

  // Clear applies first so bits set by a same-cycle handshake survive.
  always_comb begin
    sticky_d = flags_clr ? 4'd0 : sticky_q;
    if (res_valid && res_ready) begin
      sticky_d = sticky_d | flags_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sticky_q <= '0;
    end else begin
      sticky_q <= sticky_d;
    end
  end

  assign sticky_flags = sticky_q;
`endif

endmodule

// File: tb/tb_fp_mul_sequencer.sv
module tb_fp_mul_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [31:0] in_a, in_b;
  logic        mul_start;
  logic [23:0] mul_a, mul_b;
  logic        mul_done;
  logic [47:0] mul_p;
  logic        res_valid, res_ready;
  logic [31:0] res;
  logic [3:0]  res_flags;
`ifdef FPM_STICKY_FLAGS_EN
  logic        flags_clr = 1'b0;
  logic [3:0]  sticky_flags;
`endif

  int compared   = 0;
  int mismatched = 0;
  int start_cnt  = 0;

  fp_mul_sequencer #(
    .BIAS    (127),
    .TIMEOUT (32)
  ) dut (
    .clk          (clk),
    .rst          (rst),
`ifdef FPM_STICKY_FLAGS_EN
    .flags_clr    (flags_clr),
    .sticky_flags (sticky_flags),
`endif
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_a         (in_a),
    .in_b         (in_b),
    .mul_start    (mul_start),
    .mul_a        (mul_a),
    .mul_b        (mul_b),
    .mul_done     (mul_done),
    .mul_p        (mul_p),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res          (res),
    .res_flags    (res_flags)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mul_start === 1'b1) start_cnt++;
  end

  // Present an operand pair; returns at the negedge of the ISSUE cycle.
  task automatic send(input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    in_a     = a;
    in_b     = b;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Step negedges until res_valid (bounded); n = negedges stepped.
  task automatic wait_res(output int n);
    n = 0;
    while (res_valid !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic drain();
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
  endtask

  task automatic pulse_done(input logic [47:0] p);
    mul_done = 1'b1;
    mul_p    = p;
    @(negedge clk);
    mul_done = 1'b0;
    mul_p    = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0;
    mul_done = 1'b0; mul_p = '0; res_ready = 1'b0;
    repeat (2) @(negedge clk);
    compared++; if (in_ready !== 1'b1) begin mismatched++; $display("FAIL reset in_ready got %b want 1", in_ready); end
    compared++; if (mul_start !== 1'b0) begin mismatched++; $display("FAIL reset mul_start got %b want 0", mul_start); end
    compared++; if (mul_a !== 24'd0 || mul_b !== 24'd0) begin mismatched++; $display("FAIL reset mul_a/b got %h/%h want 0/0", mul_a, mul_b); end
    compared++; if (res_valid !== 1'b0) begin mismatched++; $display("FAIL reset res_valid got %b want 0", res_valid); end
    compared++; if (res !== 32'd0 || res_flags !== 4'd0) begin mismatched++; $display("FAIL reset res/flags got %h/%b want 0/0", res, res_flags); end
    rst = 1'b0;
    @(negedge clk);
    compared++; if (in_ready !== 1'b1) begin mismatched++; $display("FAIL post-reset in_ready got %b want 1", in_ready); end
  endtask

  // Normal path, including exponent boundaries at 0/1 and 254/255.
  logic [31:0] n_a   [8] = '{32'h40000000, 32'hBFC00000, 32'h7F000000, 32'h00800000,
                             32'h7F000000, 32'h7F000000, 32'h3F000000, 32'h3F800000};
  logic [31:0] n_b   [8] = '{32'h40400000, 32'h3FC00000, 32'h7F000000, 32'h00800000,
                             32'h40000000, 32'h3F800000, 32'h00800000, 32'h00800000};
  logic [47:0] n_p   [8] = '{48'h600000000000, 48'h900000000000, 48'h400000000000,
                             48'h400000000000, 48'h400000000000, 48'h400000000000,
                             48'h400000000000, 48'h400000000000};
  logic [23:0] n_ma  [8] = '{24'h800000, 24'hC00000, 24'h800000, 24'h800000,
                             24'h800000, 24'h800000, 24'h800000, 24'h800000};
  logic [23:0] n_mb  [8] = '{24'hC00000, 24'hC00000, 24'h800000, 24'h800000,
                             24'h800000, 24'h800000, 24'h800000, 24'h800000};
  logic [31:0] n_res [8] = '{32'h40C00000, 32'hC0100000, 32'h7F800000, 32'h00000000,
                             32'h7F800000, 32'h7F000000, 32'h00000000, 32'h00800000};
  logic [3:0]  n_flg [8] = '{4'b0000, 4'b0000, 4'b0010, 4'b0100,
                             4'b0010, 4'b0000, 4'b0100, 4'b0000};
  int          n_lat [8] = '{1, 3, 0, 2, 0, 1, 0, 2};

  task automatic test_normal();
    int s0, n;
    for (int i = 0; i < 8; i++) begin
      send(n_a[i], n_b[i]);
      s0 = start_cnt;
      compared++; if (mul_start !== 1'b1) begin mismatched++; $display("FAIL normal[%0d] mul_start got %b want 1", i, mul_start); end
      compared++; if (mul_a !== n_ma[i] || mul_b !== n_mb[i]) begin mismatched++; $display("FAIL normal[%0d] mul_a/b got %h/%h want %h/%h", i, mul_a, mul_b, n_ma[i], n_mb[i]); end
      for (int k = 0; k < n_lat[i]; k++) begin
        @(negedge clk);
        compared++; if (mul_start !== 1'b0 || mul_a !== n_ma[i] || res_valid !== 1'b0) begin mismatched++; $display("FAIL normal[%0d] wait hold start=%b mul_a=%h res_valid=%b want 0/%h/0", i, mul_start, mul_a, res_valid, n_ma[i]); end
      end
      if (n_lat[i] == 0) @(negedge clk);
      pulse_done(n_p[i]);
      wait_res(n);
      compared++; if (res_valid !== 1'b1) begin mismatched++; $display("FAIL normal[%0d] res_valid timeout got %b want 1", i, res_valid); end
      compared++; if (res !== n_res[i] || res_flags !== n_flg[i]) begin mismatched++; $display("FAIL normal[%0d] res/flags got %h/%b want %h/%b", i, res, res_flags, n_res[i], n_flg[i]); end
      compared++; if (start_cnt - s0 !== 1) begin mismatched++; $display("FAIL normal[%0d] mul_start pulses got %0d want 1", i, start_cnt - s0); end
      drain();
    end
  endtask

  logic [31:0] s_a   [7] = '{32'h7F800000, 32'h7FC00001, 32'hFF800000, 32'h80000000,
                             32'h00000001, 32'h00000000, 32'h7F800001};
  logic [31:0] s_b   [7] = '{32'h00000000, 32'h3F800000, 32'h40000000, 32'h40000000,
                             32'hC0000000, 32'hFF800000, 32'h00000000};
  logic [31:0] s_res [7] = '{32'h7FC00000, 32'h7FC00000, 32'hFF800000, 32'h80000000,
                             32'h80000000, 32'h7FC00000, 32'h7FC00000};
  logic [3:0]  s_flg [7] = '{4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0001};

  task automatic test_special();
    int s0;
    for (int i = 0; i < 7; i++) begin
      s0 = start_cnt;
      send(s_a[i], s_b[i]);
      compared++; if (mul_start !== 1'b0 || res_valid !== 1'b0) begin mismatched++; $display("FAIL special[%0d] issue start/valid got %b/%b want 0/0", i, mul_start, res_valid); end
      @(negedge clk);
      compared++; if (res_valid !== 1'b1) begin mismatched++; $display("FAIL special[%0d] res_valid latency got %b want 1", i, res_valid); end
      compared++; if (res !== s_res[i] || res_flags !== s_flg[i]) begin mismatched++; $display("FAIL special[%0d] res/flags got %h/%b want %h/%b", i, res, res_flags, s_res[i], s_flg[i]); end
      compared++; if (start_cnt !== s0) begin mismatched++; $display("FAIL special[%0d] mul_start pulses got %0d want 0", i, start_cnt - s0); end
      drain();
    end
  endtask

  task automatic test_timeout();
    int n;
    send(32'h40000000, 32'h40400000);
    wait_res(n);
    compared++; if (n !== 33) begin mismatched++; $display("FAIL timeout latency got %0d want 33", n); end
    compared++; if (res !== 32'h7FC00000 || res_flags !== 4'b1000) begin mismatched++; $display("FAIL timeout res/flags got %h/%b want 7fc00000/1000", res, res_flags); end
    drain();
  endtask

  task automatic test_done_at_timeout();
    int n;
    send(32'h40000000, 32'h40400000);
    repeat (32) @(negedge clk);
    compared++; if (res_valid !== 1'b0) begin mismatched++; $display("FAIL done_at_timeout early res_valid got %b want 0", res_valid); end
    pulse_done(48'h600000000000);
    wait_res(n);
    compared++; if (res !== 32'h40C00000 || res_flags !== 4'b0000) begin mismatched++; $display("FAIL done_at_timeout res/flags got %h/%b want 40c00000/0000", res, res_flags); end
    drain();
  endtask

  task automatic test_ignored_done();
    int n;
    pulse_done(48'hFFFFFFFFFFFF);
    send(32'h40000000, 32'h40400000);
    pulse_done(48'hFFFFFFFFFFFF);
    repeat (3) @(negedge clk);
    compared++; if (res_valid !== 1'b0) begin mismatched++; $display("FAIL ignored_done res_valid got %b want 0", res_valid); end
    pulse_done(48'h600000000000);
    wait_res(n);
    compared++; if (res !== 32'h40C00000 || res_flags !== 4'b0000) begin mismatched++; $display("FAIL ignored_done res/flags got %h/%b want 40c00000/0000", res, res_flags); end
    drain();
  endtask

  task automatic test_backpressure();
    send(32'h7F800000, 32'h00000000);
    @(negedge clk);
    in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      compared++; if (res_valid !== 1'b1 || res !== 32'h7FC00000 || res_flags !== 4'b0001 || in_ready !== 1'b0) begin mismatched++; $display("FAIL backpressure[%0d] valid/res/flags/in_ready got %b/%h/%b/%b want 1/7fc00000/0001/0", k, res_valid, res, res_flags, in_ready); end
    end
    res_ready = 1'b1;
    compared++; if (in_ready !== 1'b0) begin mismatched++; $display("FAIL backpressure handshake in_ready got %b want 0", in_ready); end
    @(negedge clk);
    res_ready = 1'b0;
    compared++; if (res_valid !== 1'b0 || in_ready !== 1'b1) begin mismatched++; $display("FAIL backpressure release valid/in_ready got %b/%b want 0/1", res_valid, in_ready); end
    in_valid = 1'b0;
  endtask

  task automatic test_reset_in_wait();
    send(32'h40000000, 32'h40400000);
    @(negedge clk);
    rst = 1'b1;
    #1;
    compared++; if (in_ready !== 1'b1 || mul_a !== 24'd0 || mul_b !== 24'd0 || res !== 32'd0 || res_flags !== 4'd0) begin mismatched++; $display("FAIL reset_in_wait outputs ready/a/b/res/flags got %b/%h/%h/%h/%b want 1/0/0/0/0", in_ready, mul_a, mul_b, res, res_flags); end
    @(negedge clk);
    rst = 1'b0;
    pulse_done(48'h600000000000);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      compared++; if (res_valid !== 1'b0 || mul_start !== 1'b0 || in_ready !== 1'b1 || res !== 32'd0) begin mismatched++; $display("FAIL reset_in_wait[%0d] valid/start/ready/res got %b/%b/%b/%h want 0/0/1/0", k, res_valid, mul_start, in_ready, res); end
    end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_special();
    test_timeout();
    test_done_at_timeout();
    test_ignored_done();
    test_backpressure();
    test_reset_in_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
